// File: rtl/fp_writeback_buffer.sv
// FP ALU writeback buffer: in-order result FIFO toward the FP register-file write port,
// with sticky exception flag accumulation and a one-cycle trap pulse.
module fp_writeback_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [DATA_W-1:0]        in_result,
    input  logic [RD_W-1:0]          in_rd,
    input  logic [5:0]               in_flags,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [DATA_W-1:0]        wb_data,
    output logic [RD_W-1:0]          wb_rd,
    input  logic                     flags_clr,
    input  logic [5:0]               flags_clr_mask,
    input  logic [5:0]               trap_en,
    output logic [5:0]               flags_sticky,
    output logic                     trap,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned FLAG_W = 6;
    localparam logic [2:0]  OP_NOP = 3'd0;
    localparam logic [2:0]  OP_SLT = 3'd6;

    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [RD_W-1:0]   rd_mem_q   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic [FLAG_W-1:0] sticky_q, sticky_d;
    logic              trap_q, trap_d;

    logic              accept;
    logic              push;
    logic              pop;
    logic              flag_elig;
    logic [FLAG_W-1:0] clr_bits;

    assign in_ready     = (count_q != CNT_W'(DEPTH));
    assign wb_valid     = (count_q != '0);
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign flags_sticky = sticky_q;
    assign trap         = trap_q;
    assign count        = count_q;

    // NOP is consumed without queueing; SLT queues but never raises exceptions.
    assign accept    = in_valid & in_ready;
    assign push      = accept & (in_op != OP_NOP);
    assign pop       = wb_valid & wb_ready;
    assign flag_elig = push & (in_op != OP_SLT);
    assign clr_bits  = flags_clr ? flags_clr_mask : '0;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Preload the output register with whatever will be at the head after this edge.
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                wb_data_d = in_result;
                wb_rd_d   = in_rd;
            end else begin
                wb_data_d = data_mem_q[rd_ptr_d];
                wb_rd_d   = rd_mem_q[rd_ptr_d];
            end
        end

        sticky_d = (sticky_q & ~clr_bits) | (flag_elig ? in_flags : '0);
        trap_d   = flag_elig & (|(in_flags & trap_en));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= in_result;
            rd_mem_q[wr_ptr_q]   <= in_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            sticky_q  <= '0;
            trap_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            sticky_q  <= sticky_d;
            trap_q    <= trap_d;
        end
    end

endmodule
